// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Definitions shared by the APB timer completer and its timer core:
//   - bus FSM state encoding (IDLE / SETUP / ACCESS, 2 bits)
//   - register byte offsets within the decoded PADDR[7:0] window
//   - CTRL and STATUS bit positions
//   - apply_strobe(): merges write data into a 32-bit register by byte lane
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic [7:0] OFS_CTRL   = 8'h00;
   localparam logic [7:0] OFS_LOAD   = 8'h04;
   localparam logic [7:0] OFS_VALUE  = 8'h08;
   localparam logic [7:0] OFS_STATUS = 8'h0C;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int CTRL_BITS        = 3;

   localparam int STATUS_EXPIRED   = 0;

   localparam int WAIT_CNT_W       = 4;

   // Byte lane i takes new_val where strb[i] is set, otherwise keeps old_val.
   function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_timer_core.sv
// -----------------------------------------------------------------------------
// apb_timer_core
// 32-bit down counter behind the APB timer register file.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_load            : LOAD register written this cycle
//   i_load_val        : LOAD value as it will be after this edge (post-strobe)
//   i_en              : CTRL.EN
//   i_auto_reload     : CTRL.AUTO_RELOAD
//   o_value           : current count (VALUE register)
//   o_expire          : count sits at zero while enabled; sets EXPIRED
//   o_en_clr          : expiry without auto-reload; clears CTRL.EN
// -----------------------------------------------------------------------------
module apb_timer_core
   import apb_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   input  logic        i_en,
   input  logic        i_auto_reload,
   output logic [31:0] o_value,
   output logic        o_expire,
   output logic        o_en_clr
);

   logic [31:0] r_value;
   logic        w_zero;

   assign w_zero   = (r_value == 32'd0);
   assign o_expire = i_en & w_zero;
   assign o_en_clr = o_expire & ~i_auto_reload;
   assign o_value  = r_value;

   // A bus write to LOAD takes priority over counting. The count never goes
   // below zero: at zero it either reloads or holds while EN is dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_value <= 32'd0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_en) begin
         if (!w_zero) begin
            r_value <= r_value - 32'd1;
         end else if (i_auto_reload) begin
            r_value <= i_load_val;
         end
      end
   end

endmodule

// File: rtl/apb_timer_slave.sv
// -----------------------------------------------------------------------------
// apb_timer_slave
// APB completer hosting a down-counting timer and its register file.
//   PCLK, PRESET      : clock, synchronous active-high reset
//   PSEL, PENABLE     : APB select / access phase
//   PWRITE            : 1 = write, 0 = read
//   PADDR             : byte address, only [7:0] decoded
//   PWDATA, PSTRB     : write data and byte-lane enables
//   PRDATA            : read data while PREADY on a read, else 0
//   PREADY            : transfer completes this cycle (after WAIT_STATES waits)
//   PSLVERR           : error response, meaningful only with PREADY
//   irq               : STATUS.EXPIRED & CTRL.IRQ_EN
// Register map: 0x00 CTRL (EN, AUTO_RELOAD, IRQ_EN), 0x04 LOAD,
//               0x08 VALUE (read-only), 0x0C STATUS (EXPIRED, write-1-to-clear)
// -----------------------------------------------------------------------------
module apb_timer_slave
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [3:0]            PSTRB,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  irq
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

   apb_state_e            r_state;
   apb_state_e            w_state;
   apb_state_e            w_state_nxt;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;

   logic [CTRL_BITS-1:0]  r_ctrl;
   logic [31:0]           r_load;
   logic                  r_expired;

   logic [7:0]            w_ofs;
   logic                  w_sel_ctrl;
   logic                  w_sel_load;
   logic                  w_sel_value;
   logic                  w_sel_status;
   logic                  w_misalign;
   logic                  w_err;
   logic                  w_ready;
   logic                  w_commit;
   logic                  w_wr_ctrl;
   logic                  w_wr_load;
   logic                  w_wr_status;
   logic                  w_w1c;
   logic [31:0]           w_load_nxt;
   logic [31:0]           w_value;
   logic [31:0]           w_rdata;
   logic                  w_expire;
   logic                  w_en_clr;
   logic                  w_unused_paddr;

   // Only the low byte of the address is decoded.
   assign w_unused_paddr = ^PADDR[ADDR_WIDTH-1:8];

   // ---------------------------------------------------------------------------
   // Bus FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus FSM: next state
   // The master's setup cycle is recognised in the same cycle it is presented
   // (IDLE with PSEL & !PENABLE is treated as SETUP), so the following cycle is
   // already ACCESS and a zero-wait transfer takes two bus cycles.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state = r_state;
      if (r_state == ST_IDLE && PSEL && !PENABLE) begin
         w_state = ST_SETUP;
      end

      w_state_nxt = w_state;
      case (w_state)
         ST_IDLE:   w_state_nxt = ST_IDLE;
         ST_SETUP:  w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (!PSEL) begin
               // Master abort: drop the transfer without committing.
               w_state_nxt = ST_IDLE;
            end else if (w_ready) begin
               w_state_nxt = PENABLE ? ST_IDLE : ST_SETUP;
            end
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Wait-state counter: loaded on the way into ACCESS, counts down to zero.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_wait_cnt <= '0;
      end else if (w_state == ST_SETUP) begin
         r_wait_cnt <= WAIT_INIT;
      end else if (r_state == ST_ACCESS && r_wait_cnt != '0) begin
         r_wait_cnt <= r_wait_cnt - 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_ready = (r_state == ST_ACCESS) && (r_wait_cnt == '0);
      PREADY  = w_ready;
      PSLVERR = w_ready & w_err;
      PRDATA  = '0;
      if (w_ready && !PWRITE && !w_err) begin
         PRDATA = DATA_WIDTH'(w_rdata);
      end
   end

   // ---------------------------------------------------------------------------
   // Address decode and error response
   // ---------------------------------------------------------------------------
   assign w_ofs        = PADDR[7:0];
   assign w_misalign   = (PADDR[1:0] != 2'b00);
   assign w_sel_ctrl   = (w_ofs == OFS_CTRL);
   assign w_sel_load   = (w_ofs == OFS_LOAD);
   assign w_sel_value  = (w_ofs == OFS_VALUE);
   assign w_sel_status = (w_ofs == OFS_STATUS);

   assign w_err = w_misalign
                | ~(w_sel_ctrl | w_sel_load | w_sel_value | w_sel_status)
                | (PWRITE & w_sel_value);

   // Registers change only in the completing cycle of an error-free write.
   assign w_commit    = PSEL & PENABLE & w_ready & PWRITE & ~w_err;
   assign w_wr_ctrl   = w_commit & w_sel_ctrl;
   assign w_wr_load   = w_commit & w_sel_load;
   assign w_wr_status = w_commit & w_sel_status;
   assign w_w1c       = w_wr_status & PSTRB[0] & PWDATA[STATUS_EXPIRED];

   // Post-strobe LOAD value; the core also uses it for the VALUE copy.
   assign w_load_nxt  = w_wr_load ? apply_strobe(r_load, 32'(PWDATA), PSTRB) : r_load;

   always_comb begin
      w_rdata = 32'd0;
      if (w_sel_ctrl) begin
         w_rdata = {{(32-CTRL_BITS){1'b0}}, r_ctrl};
      end else if (w_sel_load) begin
         w_rdata = r_load;
      end else if (w_sel_value) begin
         w_rdata = w_value;
      end else if (w_sel_status) begin
         w_rdata = {31'd0, r_expired};
      end
   end

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_ctrl    <= '0;
         r_load    <= 32'd0;
         r_expired <= 1'b0;
      end else begin
         // A CTRL write overrides the automatic EN clear from a one-shot expiry.
         if (w_wr_ctrl && PSTRB[0]) begin
            r_ctrl <= PWDATA[CTRL_BITS-1:0];
         end else if (w_en_clr) begin
            r_ctrl[CTRL_EN] <= 1'b0;
         end

         r_load <= w_load_nxt;

         // A new expiry beats a simultaneous write-1-to-clear.
         if (w_expire) begin
            r_expired <= 1'b1;
         end else if (w_w1c) begin
            r_expired <= 1'b0;
         end
      end
   end

   assign irq = r_expired & r_ctrl[CTRL_IRQ_EN];

   apb_timer_core u_core (
      .i_clk         (PCLK),
      .i_rst         (PRESET),
      .i_load        (w_wr_load),
      .i_load_val    (w_load_nxt),
      .i_en          (r_ctrl[CTRL_EN]),
      .i_auto_reload (r_ctrl[CTRL_AUTO_RELOAD]),
      .o_value       (w_value),
      .o_expire      (w_expire),
      .o_en_clr      (w_en_clr)
   );

endmodule

// File: tb/tb_apb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_slave
// Directed bench for apb_timer_slave. Two instances share clock and reset:
// dut1 with one wait state, dut0 with zero wait states; each has its own bus.
// -----------------------------------------------------------------------------
module tb_apb_timer_slave;
   import apb_pkg::*;

   logic        PCLK   = 1'b0;
   logic        PRESET = 1'b1;

   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [31:0] paddr   [2];
   logic [31:0] pwdata  [2];
   logic [3:0]  pstrb   [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];
   logic        irq     [2];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (psel[0]),
      .PENABLE (penable[0]),
      .PWRITE  (pwrite[0]),
      .PADDR   (paddr[0]),
      .PWDATA  (pwdata[0]),
      .PSTRB   (pstrb[0]),
      .PRDATA  (prdata[0]),
      .PREADY  (pready[0]),
      .PSLVERR (pslverr[0]),
      .irq     (irq[0])
   );

   apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(1)) dut1 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (psel[1]),
      .PENABLE (penable[1]),
      .PWRITE  (pwrite[1]),
      .PADDR   (paddr[1]),
      .PWDATA  (pwdata[1]),
      .PSTRB   (pstrb[1]),
      .PRDATA  (prdata[1]),
      .PREADY  (pready[1]),
      .PSLVERR (pslverr[1]),
      .irq     (irq[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Setup cycle, then access until PREADY; the bus is left asserted so the
   // next call can follow back-to-back. acc counts access-phase cycles.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int acc);
      logic done;
      done  = 1'b0;
      rdata = 32'd0;
      err   = 1'b0;
      acc   = 0;
      @(posedge PCLK); #1;
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wdata;
      pstrb[d]   = strb;
      @(posedge PCLK); #1;
      penable[d] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         acc++;
         if (pready[d]) begin
            rdata = prdata[d];
            err   = pslverr[d];
            done  = 1'b1;
            break;
         end
      end
      if (!done) chk("xfer_timeout", 32'(done), 32'd1);
   endtask

   task automatic idle(input int d);
      @(posedge PCLK); #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb);
      logic [31:0] rdata;
      logic        err;
      int          acc;
      xfer(d, 1'b1, addr, data, strb, rdata, err, acc);
      chk($sformatf("wr_err_%02h", addr[7:0]), 32'(err), 32'd0);
      idle(d);
   endtask

   task automatic rd_chk(input int d, input string tag, input logic [31:0] addr,
                         input logic [31:0] exp);
      logic [31:0] rdata;
      logic        err;
      int          acc;
      xfer(d, 1'b0, addr, 32'd0, 4'h0, rdata, err, acc);
      chk(tag, rdata, exp);
      chk({tag, "_err"}, 32'(err), 32'd0);
      idle(d);
   endtask

   task automatic err_chk(input int d, input string tag, input logic w,
                          input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] rdata;
      logic        err;
      int          acc;
      xfer(d, w, addr, data, 4'hF, rdata, err, acc);
      chk({tag, "_slverr"}, 32'(err), 32'd1);
      chk({tag, "_rdata"}, rdata, 32'd0);
      idle(d);
   endtask

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          c_first;
      int          c_last;
      logic [31:0] offs [4];

      for (int i = 0; i < 2; i++) begin
         psel[i]    = 1'b0;
         penable[i] = 1'b0;
         pwrite[i]  = 1'b0;
         paddr[i]   = 32'd0;
         pwdata[i]  = 32'd0;
         pstrb[i]   = 4'h0;
      end

      // Reset values
      PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_pready%0d", i),  32'(pready[i]),  32'd0);
         chk($sformatf("rst_pslverr%0d", i), 32'(pslverr[i]), 32'd0);
         chk($sformatf("rst_prdata%0d", i),  prdata[i],       32'd0);
         chk($sformatf("rst_irq%0d", i),     32'(irq[i]),     32'd0);
      end
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      // One wait state: every register reads 0, PREADY in the 2nd access cycle
      offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h0C;
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1'b0, offs[i], 32'd0, 4'h0, rdata, err, acc);
         chk($sformatf("rst_rd%02h", offs[i][7:0]),      rdata,      32'd0);
         chk($sformatf("rst_rd%02h_err", offs[i][7:0]),  32'(err),   32'd0);
         chk($sformatf("rst_rd%02h_wait", offs[i][7:0]), 32'(acc),   32'd2);
         idle(1);
      end

      // One-shot countdown 5 -> 0 on the zero-wait instance
      wr(0, 32'h04, 32'h0000_0005, 4'hF);
      xfer(0, 1'b1, 32'h00, 32'h5, 4'hF, rdata, err, acc);
      chk("ctrl_wr_err", 32'(err), 32'd0);
      xfer(0, 1'b0, 32'h08, 32'd0, 4'h0, rdata, err, acc);
      chk("cnt_v4", rdata, 32'd4);
      xfer(0, 1'b0, 32'h08, 32'd0, 4'h0, rdata, err, acc);
      chk("cnt_v2", rdata, 32'd2);
      xfer(0, 1'b0, 32'h08, 32'd0, 4'h0, rdata, err, acc);
      chk("cnt_v0", rdata, 32'd0);
      chk("irq_low_at_zero", 32'(irq[0]), 32'd0);
      idle(0);
      @(negedge PCLK);
      chk("irq_after_zero", 32'(irq[0]), 32'd1);
      rd_chk(0, "oneshot_ctrl",   32'h00, 32'h4);
      rd_chk(0, "oneshot_status", 32'h0C, 32'h1);
      rd_chk(0, "oneshot_value",  32'h08, 32'h0);
      wr(0, 32'h0C, 32'h1, 4'hF);
      @(negedge PCLK);
      chk("w1c_irq", 32'(irq[0]), 32'd0);

      // Auto-reload LOAD=3: expiry every 4 cycles; W1C on an expiry loses
      wr(0, 32'h04, 32'h3, 4'hF);
      xfer(0, 1'b1, 32'h00, 32'h7, 4'hF, rdata, err, acc);
      idle(0);
      idle(0);
      xfer(0, 1'b1, 32'h0C, 32'h1, 4'hF, rdata, err, acc);
      chk("ar_irq_before", 32'(irq[0]), 32'd0);
      xfer(0, 1'b1, 32'h0C, 32'h1, 4'hF, rdata, err, acc);
      chk("ar_set_wins", 32'(irq[0]), 32'd1);
      idle(0);
      @(negedge PCLK);
      chk("ar_cleared", 32'(irq[0]), 32'd0);
      @(negedge PCLK);
      chk("ar_not_yet", 32'(irq[0]), 32'd0);
      @(negedge PCLK);
      chk("ar_period4", 32'(irq[0]), 32'd1);
      wr(0, 32'h00, 32'h0, 4'hF);
      wr(0, 32'h0C, 32'h1, 4'hF);
      @(negedge PCLK);
      chk("ar_stop_irq", 32'(irq[0]), 32'd0);

      // Byte strobes on LOAD, VALUE follows the post-strobe LOAD
      wr(1, 32'h04, 32'hAABB_CCDD, 4'hF);
      wr(1, 32'h04, 32'h1122_3344, 4'b0101);
      rd_chk(1, "strb_load",  32'h04, 32'hAA22_CC44);
      rd_chk(1, "strb_value", 32'h08, 32'hAA22_CC44);

      // Error responses leave the registers alone
      err_chk(1, "wr_value",  1'b1, 32'h08, 32'h1234_5678);
      err_chk(1, "rd_unmap",  1'b0, 32'h10, 32'h0);
      err_chk(1, "rd_mis",    1'b0, 32'h06, 32'h0);
      err_chk(1, "wr_mis",    1'b1, 32'h05, 32'hFFFF_FFFF);
      rd_chk(1, "err_load",   32'h04, 32'hAA22_CC44);
      rd_chk(1, "err_value",  32'h08, 32'hAA22_CC44);
      rd_chk(1, "err_ctrl",   32'h00, 32'h0);
      rd_chk(1, "err_status", 32'h0C, 32'h0);

      // Back-to-back zero-wait transfers, two cycles each
      xfer(0, 1'b1, 32'h04, 32'h0000_1234, 4'hF, rdata, err, acc);
      c_first = cyc;
      chk("b2b_wr_acc", 32'(acc), 32'd1);
      xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rdata, err, acc);
      chk("b2b_rd_load", rdata, 32'h0000_1234);
      chk("b2b_rd_acc", 32'(acc), 32'd1);
      xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rdata, err, acc);
      c_last = cyc;
      chk("b2b_rd_ctrl", rdata, 32'h0);
      chk("b2b_span", 32'(c_last - c_first), 32'd4);
      idle(0);

      // Reset during the access phase of a LOAD write
      @(posedge PCLK); #1;
      psel[0]    = 1'b1;
      penable[0] = 1'b0;
      pwrite[0]  = 1'b1;
      paddr[0]   = 32'h04;
      pwdata[0]  = 32'hDEAD_BEEF;
      pstrb[0]   = 4'hF;
      @(posedge PCLK); #1;
      penable[0] = 1'b1;
      PRESET     = 1'b1;
      @(posedge PCLK); #1;
      PRESET     = 1'b0;
      psel[0]    = 1'b0;
      penable[0] = 1'b0;
      @(negedge PCLK);
      chk("abort_state", 32'(dut0.r_state), 32'(ST_IDLE));
      chk("abort_pready", 32'(pready[0]), 32'd0);
      rd_chk(0, "abort_load",  32'h04, 32'h0);
      rd_chk(0, "abort_value", 32'h08, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB completer (slave) hosting a 32-bit down-counting timer and its register file. It sits on the `PSEL_TIMER` select line driven by the APB bridge master. It answers setup/access transfers with programmable wait states, byte strobes and `PSLVERR` on illegal accesses, and raises `irq` on timer expiry.

## Interface
- `ADDR_WIDTH`, 32, PADDR width; only `PADDR[7:0]` decoded.
- `DATA_WIDTH`, 32, data bus width; fixed at 32 for this block.
- `WAIT_STATES`, 1, cycles `PREADY` is held low in the access phase (0..15).
- `PCLK` input 1: sole clock, all logic on rising edge.
- `PRESET` input 1: synchronous, active-high reset.
- `PSEL` input 1: slave select (connect to `PSEL_TIMER`).
- `PENABLE` input 1: access phase.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PADDR` input ADDR_WIDTH: byte address.
- `PWDATA` input 32: write data.
- `PSTRB` input 4: write byte-lane enables.
- `PRDATA` output 32: read data, valid while `PREADY`=1 on reads, else 0.
- `PREADY` output 1: transfer completes this cycle.
- `PSLVERR` output 1: error response, valid only while `PREADY`=1.
- `irq` output 1: level interrupt.

## Operation
- Registers (`PADDR[7:0]`):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
  - 0x04 LOAD, RW.
  - 0x08 VALUE, RO.
  - 0x0C STATUS, bit0 EXPIRED, write-1-to-clear.
- Error response: `PSLVERR`=1, no register change, `PRDATA`=0. Raised for:
  - an unmapped offset;
  - `PADDR[1:0]`≠0;
  - a write to VALUE.
- Writes commit only in the completing cycle (`PSEL & PENABLE & PREADY`). A byte lane is written only where its `PSTRB` bit is 1. STATUS W1C uses `PWDATA[0]` gated by `PSTRB[0]`.
- A write to LOAD also copies the post-strobe LOAD value into VALUE in the same edge.
- Timer, each cycle with EN=1:
  - VALUE≠0: decrement.
  - VALUE==0: set EXPIRED. If AUTO_RELOAD=1, VALUE←LOAD; else EN←0.
- `irq` = EXPIRED & IRQ_EN, combinational from registers.
- Simultaneous events:
  - W1C and a new expiry in the same cycle: set wins.
  - LOAD write and a timer decrement in the same cycle: the write wins.
  - CTRL write clearing EN and an expiry in the same cycle: EXPIRED still sets.
- Bus FSM states IDLE, SETUP, ACCESS:
  - IDLE→SETUP on `PSEL & !PENABLE`.
  - SETUP→ACCESS unconditionally; wait counter loads WAIT_STATES.
  - ACCESS: `PREADY` = (counter==0). While the counter≠0 it decrements.
  - On completion: →SETUP if `PSEL & !PENABLE` is already asserted, else →IDLE.
  - ACCESS with `PSEL`=0 (master abort) → IDLE, no commit.

## Timing
- Reset: state IDLE; CTRL, LOAD, VALUE, STATUS = 0. `PREADY`, `PSLVERR`, `irq` = 0 and `PRDATA` = 0.
- A reset asserted mid-transfer abandons it: no commit, and the master must reissue.
- Latency: `PREADY` rises WAIT_STATES cycles after the first access-phase cycle. WAIT_STATES=0 gives a zero-wait transfer (2 bus cycles total).
- `PREADY`, `PRDATA` and `PSLVERR` are combinational from the registered state, counter and registers. `PRDATA` reflects register contents at the completing cycle.
- A written value is visible to a read completing one or more cycles later. VALUE reads return the pre-edge count.
- VALUE wraps only via reload, never below 0. A LOAD of 0 with EN=1 expires every cycle.

## Structure
- Shared package `apb_pkg`: FSM state encoding (IDLE/SETUP/ACCESS, 2 bits), register offset constants, CTRL/STATUS bit indices.
- Sub-module `apb_timer_core`:
  - inputs: load strobe/value, EN, AUTO_RELOAD;
  - outputs: VALUE, expire pulse, EN-clear pulse.
- Bus FSM and register file stay in `apb_timer_slave`.

## Test plan
- Reset, then read all four registers with WAIT_STATES=1 → each returns 0 with `PREADY` high exactly one cycle after PENABLE rises, `PSLVERR`=0.
- Write LOAD=0x0000_0005 with PSTRB=4'b1111, then CTRL=0x5 (EN, IRQ_EN) → VALUE counts 5→0. EXPIRED and `irq` rise the cycle after VALUE reads 0, EN clears, and VALUE holds 0.
- LOAD=0x3, CTRL=0x7 (auto-reload) → EXPIRED set every 4 cycles. Write STATUS=0x1 the cycle an expiry occurs → EXPIRED stays 1 (set wins).
- Write LOAD=0xAABB_CCDD, then write 0x1122_3344 with PSTRB=4'b0101 → LOAD reads 0xAA22_CC44.
- Write to 0x08, read 0x10, read 0x06 → each completes with `PSLVERR`=1, `PRDATA`=0, and no register changes.
- Back-to-back transfers with WAIT_STATES=0, plus PRESET asserted mid-ACCESS of a LOAD write → the back-to-back transfers each complete in 2 cycles; the reset-aborted LOAD stays 0 and the FSM is in IDLE.
